// File: rtl/lms_adapt_ctrl.sv
// Sequencing controller for a two-tap LMS adaptive filter: flush, coarse-step
// training, lock detection, fine-step tracking, freeze/hold, abort and timeout.
module lms_adapt_ctrl #(
  parameter int unsigned DW        = 16,
  parameter int unsigned FLUSH_LEN = 4,
  parameter int unsigned WIN       = 8,
  parameter int unsigned ERR_THR   = 64,
  parameter int unsigned MAX_TRAIN = 4096,
  parameter int unsigned MU_TRAIN  = 10,
  parameter int unsigned MU_TRACK  = 12,
  localparam int unsigned SW       = $clog2(MAX_TRAIN + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_freeze,
  input  logic          i_sample_valid,
  input  logic [DW-1:0] i_err_in,
  output logic          o_filt_clr,
  output logic          o_adapt_en,
  output logic [3:0]    o_mu_shift,
  output logic [2:0]    o_state,
  output logic          o_converged,
  output logic          o_timeout,
  output logic [SW-1:0] o_samp_cnt
);

  localparam int unsigned FW    = $clog2(FLUSH_LEN + 1);
  localparam int unsigned GW    = $clog2(WIN + 1);
  localparam int unsigned ThrHi = 4 * ERR_THR;

  localparam logic [FW-1:0] FlushLast = FW'(FLUSH_LEN - 1);
  localparam logic [GW-1:0] WinC      = GW'(WIN);
  localparam logic [SW-1:0] MaxC      = SW'(MAX_TRAIN);
  localparam logic [3:0]    MuTrain   = 4'(MU_TRAIN);
  localparam logic [3:0]    MuTrack   = 4'(MU_TRACK);
  localparam logic [DW-1:0] MinNeg    = {1'b1, {(DW - 1){1'b0}}};
  localparam logic [DW-1:0] MaxPos    = {1'b0, {(DW - 1){1'b1}}};

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFlush = 3'd1,
    StTrain = 3'd2,
    StTrack = 3'd3,
    StHold  = 3'd4,
    StFail  = 3'd5
  } state_e;

  state_e        r_state, w_state_d;
  state_e        r_ret, w_ret_d;
  logic [FW-1:0] r_flush_cnt, w_flush_cnt_d;
  logic [GW-1:0] r_good_cnt, w_good_cnt_d;
  logic [GW-1:0] r_bad_cnt, w_bad_cnt_d;
  logic [SW-1:0] r_samp_cnt, w_samp_cnt_d;

  logic [DW-1:0] w_err_neg, w_mag;
  logic [31:0]   w_mag32;
  logic          w_is_good, w_is_bad, w_in_track;
  logic [GW-1:0] w_good_nxt, w_bad_nxt;
  logic [SW-1:0] w_samp_nxt;

  // Error magnitude; the most negative code saturates to the largest positive one.
  assign w_err_neg = ~i_err_in + DW'(1);
  assign w_mag     = !i_err_in[DW-1] ? i_err_in :
                     (i_err_in == MinNeg) ? MaxPos : w_err_neg;
  assign w_mag32   = 32'(w_mag);
  assign w_is_good = w_mag32 < ERR_THR;
  assign w_is_bad  = w_mag32 >= ThrHi;

  // Saturating candidate counter values for the current sample.
  assign w_good_nxt = !w_is_good ? '0 : (r_good_cnt == WinC) ? r_good_cnt : r_good_cnt + GW'(1);
  assign w_bad_nxt  = !w_is_bad  ? '0 : (r_bad_cnt == WinC)  ? r_bad_cnt  : r_bad_cnt + GW'(1);
  assign w_samp_nxt = (r_samp_cnt == MaxC) ? r_samp_cnt : r_samp_cnt + SW'(1);

  // Next-state and counter update; abort > freeze > start > sample-driven.
  always_comb begin
    w_state_d     = r_state;
    w_ret_d       = r_ret;
    w_flush_cnt_d = r_flush_cnt;
    w_good_cnt_d  = r_good_cnt;
    w_bad_cnt_d   = r_bad_cnt;
    w_samp_cnt_d  = r_samp_cnt;
    if (i_abort) begin
      w_state_d     = StIdle;
      w_ret_d       = StIdle;
      w_flush_cnt_d = '0;
      w_good_cnt_d  = '0;
      w_bad_cnt_d   = '0;
      w_samp_cnt_d  = '0;
    end else begin
      unique case (r_state)
        StIdle, StFail: begin
          if (i_start) begin
            w_state_d     = StFlush;
            w_flush_cnt_d = '0;
            w_good_cnt_d  = '0;
            w_bad_cnt_d   = '0;
            w_samp_cnt_d  = '0;
          end
        end
        StFlush: begin
          if (r_flush_cnt == FlushLast) w_state_d = StTrain;
          else w_flush_cnt_d = r_flush_cnt + FW'(1);
        end
        StTrain: begin
          if (i_freeze) begin
            w_state_d = StHold;
            w_ret_d   = StTrain;
          end else if (i_sample_valid) begin
            w_samp_cnt_d = w_samp_nxt;
            w_good_cnt_d = w_good_nxt;
            if (w_good_nxt == WinC) begin
              w_state_d   = StTrack;
              w_bad_cnt_d = '0;
            end else if (w_samp_nxt == MaxC) begin
              w_state_d = StFail;
            end
          end
        end
        StTrack: begin
          if (i_freeze) begin
            w_state_d = StHold;
            w_ret_d   = StTrack;
          end else if (i_sample_valid) begin
            w_bad_cnt_d = w_bad_nxt;
            if (w_bad_nxt == WinC) begin
              w_state_d    = StTrain;
              w_good_cnt_d = '0;
              w_bad_cnt_d  = '0;
              w_samp_cnt_d = '0;
            end
          end
        end
        StHold: begin
          if (!i_freeze) w_state_d = r_ret;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_ret       <= StIdle;
      r_flush_cnt <= '0;
      r_good_cnt  <= '0;
      r_bad_cnt   <= '0;
      r_samp_cnt  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_ret       <= w_ret_d;
      r_flush_cnt <= w_flush_cnt_d;
      r_good_cnt  <= w_good_cnt_d;
      r_bad_cnt   <= w_bad_cnt_d;
      r_samp_cnt  <= w_samp_cnt_d;
    end
  end

  // Outputs decode registered state only; HOLD keeps the step size of its return state.
  assign w_in_track  = (r_state == StTrack) || ((r_state == StHold) && (r_ret == StTrack));
  assign o_state     = r_state;
  assign o_filt_clr  = (r_state == StFlush);
  assign o_adapt_en  = (r_state == StTrain) || (r_state == StTrack);
  assign o_converged = w_in_track;
  assign o_mu_shift  = w_in_track ? MuTrack : MuTrain;
  assign o_timeout   = (r_state == StFail);
  assign o_samp_cnt  = r_samp_cnt;

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Directed bench for lms_adapt_ctrl (MAX_TRAIN shortened to 16).
module tb_lms_adapt_ctrl;

  localparam int unsigned DW   = 16;
  localparam int unsigned MAXT = 16;
  localparam int unsigned SW   = $clog2(MAXT + 1);

  logic          clk = 1'b0;
  logic          rst_n, start, abort, freeze, sample_valid;
  logic [DW-1:0] err_in;
  logic          filt_clr, adapt_en, converged, timeout;
  logic [3:0]    mu_shift;
  logic [2:0]    state;
  logic [SW-1:0] samp_cnt;
  logic [10:0]   obs;
  logic [10:0]   e;
  int            n_checks = 0;
  int            n_fail = 0;

  lms_adapt_ctrl #(.MAX_TRAIN(MAXT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_freeze(freeze),
    .i_sample_valid(sample_valid), .i_err_in(err_in), .o_filt_clr(filt_clr),
    .o_adapt_en(adapt_en), .o_mu_shift(mu_shift), .o_state(state), .o_converged(converged),
    .o_timeout(timeout), .o_samp_cnt(samp_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {state, filt_clr, adapt_en, mu_shift, converged, timeout};

  function automatic logic [10:0] ev(input logic [2:0] st, input logic clr, input logic en,
                                     input logic [3:0] mu, input logic cv, input logic to);
    return {st, clr, en, mu, cv, to};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] v);
    sample_valid = 1'b1;
    err_in       = v;
    tick();
    sample_valid = 1'b0;
    err_in       = '0;
  endtask

  task automatic send_n(input logic [DW-1:0] v, input int n);
    repeat (n) send(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; freeze = 1'b0; sample_valid = 1'b0; err_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Start pulse, then four FLUSH cycles, then TRAIN with cleared sample count.
  task automatic run_flush();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = ev(3'd1, 1'b1, 1'b0, 4'd10, 1'b0, 1'b0);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL flush_cyc%0d got=%h exp=%h", i, obs, e); end
      tick();
    end
    e = ev(3'd2, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL flush_to_train got=%h exp=%h", obs, e); end
    n_checks++;
    if (samp_cnt !== SW'(0)) begin
      n_fail++; $display("FAIL flush_samp got=%0d exp=0", samp_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; freeze = 1'b0; sample_valid = 1'b0; err_in = '0;
    #1;
    e = ev(3'd0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_obs got=%h exp=%h", obs, e); end
    n_checks++;
    if (samp_cnt !== SW'(0)) begin n_fail++; $display("FAIL reset_samp got=%0d exp=0", samp_cnt); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL idle_obs got=%h exp=%h", obs, e); end
  endtask

  task automatic test_lock();
    run_flush();
    send_n(16'd10, 7);
    e = ev(3'd2, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL lock_pre got=%h exp=%h", obs, e); end
    n_checks++;
    if (samp_cnt !== SW'(7)) begin n_fail++; $display("FAIL lock_samp got=%0d exp=7", samp_cnt); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (obs !== e || samp_cnt !== SW'(7)) begin
      n_fail++; $display("FAIL start_ignored got=%h/%0d exp=%h/7", obs, samp_cnt, e);
    end
    send(16'd10);
    e = ev(3'd3, 1'b0, 1'b1, 4'd12, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL lock_8th got=%h exp=%h", obs, e); end
  endtask

  // Interrupted run; the final lock lands on sample 16 = MAX_TRAIN, so lock must win.
  task automatic test_lock_interrupted();
    do_reset();
    run_flush();
    send_n(16'd10, 7);
    send(16'd200);
    send_n(16'd10, 7);
    e = ev(3'd2, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e || samp_cnt !== SW'(15)) begin
      n_fail++; $display("FAIL relock_pre got=%h/%0d exp=%h/15", obs, samp_cnt, e);
    end
    send(16'd10);
    e = ev(3'd3, 1'b0, 1'b1, 4'd12, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL relock_tie got=%h exp=%h", obs, e); end
  endtask

  task automatic test_unlock();
    send_n(-16'sd300, 7);
    send(16'd0);
    e = ev(3'd3, 1'b0, 1'b1, 4'd12, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL unlock_broken got=%h exp=%h", obs, e); end
    send_n(-16'sd300, 7);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL unlock_pre got=%h exp=%h", obs, e); end
    send(16'h8000);
    e = ev(3'd2, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL unlock_minneg got=%h exp=%h", obs, e); end
    n_checks++;
    if (samp_cnt !== SW'(0)) begin n_fail++; $display("FAIL unlock_samp got=%0d exp=0", samp_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    run_flush();
    send_n(16'd500, 15);
    e = ev(3'd2, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e || samp_cnt !== SW'(15)) begin
      n_fail++; $display("FAIL to_pre got=%h/%0d exp=%h/15", obs, samp_cnt, e);
    end
    send(16'd500);
    e = ev(3'd5, 1'b0, 1'b0, 4'd10, 1'b0, 1'b1);
    n_checks++;
    if (obs !== e || samp_cnt !== SW'(16)) begin
      n_fail++; $display("FAIL to_fail got=%h/%0d exp=%h/16", obs, samp_cnt, e);
    end
    freeze = 1'b1;
    tick();
    freeze = 1'b0;
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL to_freeze_ign got=%h exp=%h", obs, e); end
    start = 1'b1;
    tick();
    start = 1'b0;
    e = ev(3'd1, 1'b1, 1'b0, 4'd10, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e || samp_cnt !== SW'(0)) begin
      n_fail++; $display("FAIL to_restart got=%h/%0d exp=%h/0", obs, samp_cnt, e);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    run_flush();
    send_n(16'd10, 5);
    freeze       = 1'b1;
    sample_valid = 1'b1;
    err_in       = 16'd10;
    e = ev(3'd4, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (obs !== e || samp_cnt !== SW'(5)) begin
        n_fail++; $display("FAIL hold_cyc%0d got=%h/%0d exp=%h/5", i, obs, samp_cnt, e);
      end
    end
    freeze       = 1'b0;
    sample_valid = 1'b0;
    tick();
    e = ev(3'd2, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e || samp_cnt !== SW'(5)) begin
      n_fail++; $display("FAIL hold_resume got=%h/%0d exp=%h/5", obs, samp_cnt, e);
    end
    send_n(16'd10, 2);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL hold_pre_lock got=%h exp=%h", obs, e); end
    send(16'd10);
    e = ev(3'd3, 1'b0, 1'b1, 4'd12, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL hold_lock got=%h exp=%h", obs, e); end
    freeze = 1'b1;
    tick();
    e = ev(3'd4, 1'b0, 1'b0, 4'd12, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL hold_track got=%h exp=%h", obs, e); end
    freeze = 1'b0;
    tick();
    e = ev(3'd3, 1'b0, 1'b1, 4'd12, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL hold_track_ret got=%h exp=%h", obs, e); end
  endtask

  task automatic test_abort();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    e = ev(3'd0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e || samp_cnt !== SW'(0)) begin
      n_fail++; $display("FAIL abort got=%h/%0d exp=%h/0", obs, samp_cnt, e);
    end
    run_flush();
  endtask

  task automatic test_async_reset();
    send_n(16'd10, 3);
    #2 rst_n = 1'b0;
    #1;
    e = ev(3'd0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e || samp_cnt !== SW'(0)) begin
      n_fail++; $display("FAIL async_rst got=%h/%0d exp=%h/0", obs, samp_cnt, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL async_rst_idle got=%h exp=%h", obs, e); end
    run_flush();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_unlock();
    test_lock_interrupted();
    test_timeout();
    test_freeze();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lms_adapt_ctrl.md
# lms_adapt_ctrl

Sequencing controller for the two-tap LMS adaptive filter datapath. It flushes the filter delay line and coefficients, then runs a training phase with a coarse step size. It detects convergence from the filter error stream, switches to a fine-step tracking phase, and supports freeze/abort. It also flags training timeout. It sits beside the filter: it consumes the filter's error samples and drives the filter's clear, adaptation-enable and step-size controls.

## Interface
- DW, 16: error sample width (signed)
- FLUSH_LEN, 4: clock cycles of filter clear after start
- WIN, 8: consecutive qualifying samples for lock / loss-of-lock
- ERR_THR, 64: lock threshold on |err|; loss-of-lock threshold is 4*ERR_THR
- MAX_TRAIN, 4096: sample budget in TRAIN before timeout
- MU_TRAIN, 10: step-size shift during TRAIN
- MU_TRACK, 12: step-size shift during TRACK
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, asynchronous assert, active-low
- start  in  1  pulse: begin (re)training from IDLE or FAIL
- abort  in  1  level: force IDLE
- freeze  in  1  level: suspend adaptation in TRAIN/TRACK
- sample_valid  in  1  err_in valid this cycle
- err_in  in  DW  signed filter error d - y
- filt_clr  out  1  clear filter delay line and coefficients
- adapt_en  out  1  enable coefficient update
- mu_shift  out  4  right-shift applied to error*x update
- state  out  3  IDLE=0 FLUSH=1 TRAIN=2 TRACK=3 HOLD=4 FAIL=5
- converged  out  1  high while in TRACK, or in HOLD entered from TRACK
- timeout  out  1  high in FAIL
- samp_cnt  out  clog2(MAX_TRAIN+1)  samples consumed in current TRAIN

## Operation
- |err|: magnitude of err_in, with -2^(DW-1) saturated to 2^(DW-1)-1. Compares are unsigned.
- IDLE: all outputs 0, mu_shift=MU_TRAIN. start -> FLUSH.
- FLUSH: filt_clr=1 for exactly FLUSH_LEN cycles, then -> TRAIN. good_cnt, bad_cnt and samp_cnt are cleared on entry.
- TRAIN: adapt_en=1, mu_shift=MU_TRAIN. On each sample_valid:
  - samp_cnt increments.
  - If |err|<ERR_THR, good_cnt increments; otherwise good_cnt resets to 0.
  - good_cnt reaching WIN -> TRACK.
  - Otherwise, samp_cnt reaching MAX_TRAIN -> FAIL.
  - If both occur on the same sample, convergence wins.
- TRACK: adapt_en=1, mu_shift=MU_TRACK, converged=1. On each sample_valid:
  - If |err|>=4*ERR_THR, bad_cnt increments; otherwise bad_cnt resets to 0.
  - bad_cnt reaching WIN -> TRAIN. This clears good_cnt and samp_cnt and drops converged.
- HOLD:
  - Entered from TRAIN or TRACK while freeze=1. The return state is saved.
  - adapt_en=0. mu_shift, converged and all counters hold. sample_valid is ignored.
  - When freeze falls, return to the saved state.
- FAIL: timeout=1, adapt_en=0. start -> FLUSH (timeout clears). freeze is ignored.
- Precedence each cycle: abort > freeze > start > sample-driven transitions.
  - abort from any state -> IDLE and clears all counters.
  - start outside IDLE/FAIL is ignored.
- good_cnt and bad_cnt saturate at WIN. samp_cnt saturates at MAX_TRAIN.

## Timing
- All outputs are registered and decoded from the state/counters after the clock edge. Nothing is combinational from the inputs.
- start sampled at edge N: state=FLUSH and filt_clr=1 from N+1 through N+FLUSH_LEN. TRAIN and adapt_en=1 from N+FLUSH_LEN+1.
- The WIN-th qualifying sample, sampled at edge N, gives state=TRACK, converged=1 and mu_shift=MU_TRACK from N+1.
- freeze seen at edge N gives adapt_en=0 at N+1. freeze low at edge M resumes at M+1.
- Reset (rst=0) asynchronously forces IDLE, clears all counters and the saved state, sets every output to 0 and mu_shift=MU_TRAIN. Release is synchronized by the caller.
- Reset or abort mid-FLUSH/TRAIN/TRACK: the next start restarts from FLUSH with full FLUSH_LEN.
- sample_valid may be high every cycle or sparse. Gaps do not reset counters.

## Test plan
- Reset then start at cycle 0: filt_clr high cycles 1-4, state=2 and adapt_en=1 at cycle 5, mu_shift=10.
- In TRAIN, 8 valid samples of err=10: converged=1 and mu_shift=12 the cycle after the 8th. With err=10 x7, 200, 10 x8: no lock until the final run of 8 completes.
- In TRACK, 8 samples of err=-300 (>=256): state returns to 2 and converged=0. Seven such samples followed by err=0: stays in TRACK. err=-32768 counts as |err|=32767.
- With MAX_TRAIN=16 and err=500 throughout: state=5 and timeout=1 after the 16th sample. Then start: state=1 and timeout=0 the next cycle.
- freeze for 20 cycles during TRAIN with 5 good samples counted: adapt_en=0 and samp_cnt unchanged during freeze. After release, 3 more good samples give lock.
- abort and start asserted together in TRACK -> IDLE. Asserting rst asynchronously mid-cycle gives all outputs 0 before the next edge.
